// File: rtl/ra_pq_sys_wrapper.sv
// Systolic min-priority queue of {key,value} pairs with full/busy/empty status.
// Optional seven-segment display driver enabled by defining RA_PQ_S_DISPLAY_EN.
module ra_pq_sys_wrapper #(
  parameter int DEPTH        = 8,
  parameter int KW           = 8,
  parameter int VW           = 8,
  parameter int REFRESH_BITS = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KW+VW-1:0]  kvi_logic,
  input  logic              enq_deq,
  input  logic              deq,
  output logic              full,
  output logic              busy,
  output logic              empty,
  output logic [6:0]        segs_n,
  output logic              dp_n,
  output logic [7:0]        an_n
);
  localparam int W  = KW + VW;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld, vld_nxt, bvld, stay;
  logic [W-1:0]     kv [DEPTH];
  logic [W-1:0]     kv_nxt [DEPTH];
  logic [W-1:0]     bkv [DEPTH];
  logic [CW-1:0]    count, count_nxt;
  logic             do_deq, do_rep, do_enq, shift, ins;
  logic             last_vld;
  logic [W-1:0]     last_kv;
  logic             head_vld;
  logic [W-1:0]     head_kv;

  assign head_vld = vld[0];
  assign head_kv  = kv[0];

  // Replace on an empty queue degenerates into a plain enqueue.
  assign do_rep = enq_deq && deq && !busy && !empty;
  assign do_deq = deq && !enq_deq && !busy && !empty;
  assign do_enq = enq_deq && !busy && (deq ? empty : !full);
  assign shift  = do_deq || do_rep;
  assign ins    = do_enq || do_rep;

  // Base array is the queue after an optional head removal; insertion then
  // happens into it, so replace reuses the same compare/shift network.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      bvld[i] = shift ? vld[i+1] : vld[i];
      bkv[i]  = shift ? kv[i+1]  : kv[i];
    end
    bvld[DEPTH-1] = shift ? 1'b0 : vld[DEPTH-1];
    bkv[DEPTH-1]  = kv[DEPTH-1];
    for (int i = 0; i < DEPTH; i++)
      stay[i] = bvld[i] && (bkv[i][W-1:VW] <= kvi_logic[W-1:VW]);
    vld_nxt = bvld;
    for (int i = 0; i < DEPTH; i++) kv_nxt[i] = bkv[i];
    if (ins) begin
      if (!stay[0]) begin
        vld_nxt[0] = 1'b1;
        kv_nxt[0]  = kvi_logic;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (!stay[i]) begin
          vld_nxt[i] = stay[i-1] ? 1'b1 : bvld[i-1];
          kv_nxt[i]  = stay[i-1] ? kvi_logic : bkv[i-1];
        end
      end
    end
    count_nxt = count + CW'(ins) - CW'(shift);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld      <= '0;
      for (int i = 0; i < DEPTH; i++) kv[i] <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      busy     <= 1'b0;
      last_vld <= 1'b0;
      last_kv  <= '0;
    end else begin
      vld <= vld_nxt;
      for (int i = 0; i < DEPTH; i++) kv[i] <= kv_nxt[i];
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
      busy  <= shift;
      if (shift) begin
        last_vld <= 1'b1;
        last_kv  <= kv[0];
      end
    end
  end

`ifdef RA_PQ_S_DISPLAY_EN
  logic [REFRESH_BITS-1:0] refresh;
  logic [2:0]              digit;
  logic [3:0]              nib;
  logic                    blank;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh <= '0;
      digit   <= '0;
    end else begin
      refresh <= refresh + 1'b1;
      if (&refresh) digit <= digit + 1'b1;
    end
  end

  always_comb begin
    nib   = 4'h0;
    blank = 1'b1;
    case (digit)
      3'd0: begin nib = head_kv[3:0];        blank = !head_vld; end
      3'd1: begin nib = head_kv[7:4];        blank = !head_vld; end
      3'd2: begin nib = head_kv[W-1-4:VW];   blank = !head_vld; end
      3'd3: begin nib = head_kv[W-1:W-4];    blank = !head_vld; end
      3'd4: begin nib = last_kv[3:0];        blank = !last_vld; end
      3'd5: begin nib = last_kv[7:4];        blank = !last_vld; end
      3'd6: begin nib = last_kv[W-1-4:VW];   blank = !last_vld; end
      default: begin nib = last_kv[W-1:W-4]; blank = !last_vld; end
    endcase
  end

  assign segs_n = blank ? 7'h7F : hex7(nib);
  assign an_n   = ~(8'b1 << digit);
  assign dp_n   = (digit != 3'd4);
`else
  logic unused_disp;
  assign unused_disp = ^{last_vld, last_kv, head_vld, head_kv, REFRESH_BITS[0]};
  assign segs_n = 7'h7F;
  assign dp_n   = 1'b1;
  assign an_n   = 8'hFF;
`endif

endmodule

// File: tb/tb_ra_pq_sys_wrapper.sv
// Scoreboard bench for ra_pq_sys_wrapper: a sorted-queue model predicts status
// and head each cycle; predicted dequeued entries are queued and matched on busy.
module tb_ra_pq_sys_wrapper;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] kvi_logic = '0;
  logic        enq_deq = 1'b0;
  logic        deq = 1'b0;
  logic        full, busy, empty, dp_n;
  logic [6:0]  segs_n;
  logic [7:0]  an_n;

  int total = 0;
  int bad   = 0;

  logic [15:0] mq[$];
  logic [15:0] sb[$];
  logic        mbusy = 1'b0;

  ra_pq_sys_wrapper dut (
    .clk(clk), .rst(rst), .kvi_logic(kvi_logic), .enq_deq(enq_deq), .deq(deq),
    .full(full), .busy(busy), .empty(empty), .segs_n(segs_n), .dp_n(dp_n), .an_n(an_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_insert(input logic [15:0] v);
    int p;
    p = mq.size();
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i][15:8] > v[15:8]) p = i;
    mq.insert(p, v);
  endtask

  task automatic step(input logic e, input logic d, input logic [15:0] v);
    logic nb;
    @(negedge clk);
    enq_deq = e; deq = d; kvi_logic = v;
    nb = 1'b0;
    if (!mbusy) begin
      if (e && d && mq.size() > 0) begin
        sb.push_back(mq.pop_front());
        model_insert(v);
        nb = 1'b1;
      end else if (e && (d || mq.size() < 8)) begin
        model_insert(v);
      end else if (d && !e && mq.size() > 0) begin
        sb.push_back(mq.pop_front());
        nb = 1'b1;
      end
    end
    mbusy = nb;
    @(posedge clk); #1;
    chk("full",  full,  mq.size() == 8);
    chk("empty", empty, mq.size() == 0);
    chk("busy",  busy,  mbusy);
    chk("count", dut.count, mq.size());
    if (mq.size() > 0) chk("head", dut.head_kv, mq[0]);
  endtask

  // Each cycle with busy high follows exactly one removal of the head.
  always @(posedge clk) begin
    #1;
    if (!rst && busy === 1'b1) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else chk("deq_kv", dut.last_kv, sb.pop_front());
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    logic [7:0] keys [8];
    keys = '{8'h8E, 8'hBB, 8'h99, 8'hAA, 8'h11, 8'h77, 8'h55, 8'hCC};
    repeat (10) @(posedge clk);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full",  full,  0);
    chk("rst_busy",  busy,  0);
    chk("rst_segs",  segs_n, 7'h7F);
    chk("rst_dp",    dp_n, 1);
`ifdef RA_PQ_S_DISPLAY_EN
    chk("rst_an", an_n, 8'hFE);
`else
    chk("rst_an", an_n, 8'hFF);
`endif
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, {keys[i], 8'hCC});
    chk("fill_head", dut.head_kv, 16'h11CC);
`ifdef RA_PQ_S_DISPLAY_EN
    chk("disp_d0", segs_n, 7'h46);
`endif
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 16'h0);
    chk("drained", mq.size() == 0 && empty, 1);
    idle(1);

    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, {keys[i], 8'hCC});
    step(1'b1, 1'b0, 16'h00CC);
    chk("full_ign_head", dut.head_kv, 16'h11CC);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'h0);
    idle(1);

    step(1'b1, 1'b0, 16'h4001);
    step(1'b1, 1'b0, 16'h4002);
    step(1'b0, 1'b1, 16'h0);
    chk("eq_first", dut.last_kv, 16'h4001);
    step(1'b1, 1'b0, 16'h0155);
    step(1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b1, 16'h0);
    chk("eq_second", dut.last_kv, 16'h4002);
    idle(1);

    step(1'b1, 1'b1, 16'h3033);
    step(1'b1, 1'b0, 16'h11CC);
    step(1'b1, 1'b0, 16'h55CC);
    step(1'b1, 1'b1, 16'h20AA);
    chk("rep_last", dut.last_kv, 16'h11CC);
    chk("rep_head", dut.head_kv, 16'h20AA);
    step(1'b1, 1'b1, 16'h0101);
    idle(2);
    chk("rep_count", dut.count, 3);

    step(1'b0, 1'b1, 16'h0);
    rst = 1'b1;
    #1;
    chk("midrst_busy",  busy,  0);
    chk("midrst_empty", empty, 1);
    mq.delete();
    mbusy = 1'b0;
    @(negedge clk); rst = 1'b0;
    idle(2);
    chk("sb_left", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ra_pq_sys_wrapper.md
# ra_pq_sys_wrapper

Register-array (systolic) min-priority queue of key/value pairs with board-level status and an 8-digit seven-segment display driver. It sits at the top of the FPGA demo design: switches supply a 16-bit key/value word, buttons request enqueue or dequeue, LEDs show full/busy/empty, and the display shows the current head and the last dequeued entry.

## Interface
- DEPTH, 8, number of queue entries.
- KW, 8, key width; key = kvi_logic[15:8].
- VW, 8, value width; value = kvi_logic[7:0].
- REFRESH_BITS, 17, display refresh counter width; digit advances when the low REFRESH_BITS bits wrap.
- clk  in  1  single system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- kvi_logic  in  16  {key, value} to enqueue.
- enq_deq  in  1  enqueue request (level, sampled every cycle).
- deq  in  1  dequeue request (level, sampled every cycle).
- full  out  1  queue holds DEPTH entries.
- busy  out  1  queue is shifting after a dequeue; requests ignored.
- empty  out  1  queue holds 0 entries.
- segs_n  out  7  active-low segments {g,f,e,d,c,b,a}.
- dp_n  out  1  active-low decimal point.
- an_n  out  8  active-low digit enables, one-hot-low.

## Operation
- Storage: DEPTH slots, each {valid, key, value}; slot 0 is the head (smallest key). Slots kept sorted ascending; valid slots contiguous from slot 0.
- Enqueue (enq_deq=1, deq=0, not full, not busy): each slot compares its key with the new key in parallel; new entry inserted after all entries with key <= new key (equal keys leave in FIFO order); larger entries shift one slot up. Completes in one cycle.
- Dequeue (deq=1, enq_deq=0, not empty, not busy): head copied to the last-dequeued register; all slots shift down one. busy asserted the following cycle.
- Replace (enq_deq=1 and deq=1, not busy): if empty, behaves as enqueue; otherwise head removed to last-dequeued register and new entry inserted in sorted position among remaining entries in the same cycle; count unchanged; busy asserted next cycle.
- Enqueue while full: ignored, no state change. Dequeue while empty: ignored. Any request while busy: ignored.
- Count: 0..DEPTH; full = (count==DEPTH), empty = (count==0), both registered from state.
- Display: 3-bit digit index from refresh counter. Digits 3..0 show head key (3,2) and value (1,0) as hex; blank (segs_n=7'h7F) when empty. Digits 7..4 show last dequeued key/value; blank until first dequeue. dp_n=0 only when digit 4 is active; otherwise 1.

## Timing
- Reset (async): all slots invalid, count=0, empty=1, full=0, busy=0, last-dequeued invalid, refresh counter and digit index 0, an_n=8'hFE, segs_n=7'h7F, dp_n=1.
- Enqueue: new entry visible at head/full/empty one cycle after the sampling edge; back-to-back enqueues every cycle accepted.
- Dequeue: head and count update one cycle after sampling edge; busy=1 for exactly that next cycle; with deq held high, one dequeue every 2 cycles.
- busy deasserts automatically; rst mid-shift clears busy and queue immediately.
- an_n/segs_n/dp_n are combinational from registered digit index and queue state.

## Configuration
- RA_PQ_S_DISPLAY_EN defined: refresh counter and seven-segment driver as above.
- Not defined: no refresh/decoder logic; segs_n=7'h7F, dp_n=1, an_n=8'hFF constantly; queue and status unaffected.

## Test plan
- Reset for 10 cycles -> empty=1, full=0, busy=0, an_n=8'hFE, segs_n=7'h7F.
- Enqueue keys 8E,BB,99,AA,11,77,55,CC (value CC) on 8 consecutive cycles -> full=1 after 8th, head=11CC, no busy.
- Hold deq=1, enq_deq=0 for 50 cycles -> dequeue order 11,55,77,8E,99,AA,BB,CC, busy toggles, empty=1 after 16 cycles, later deqs ignored.
- Enqueue 9th entry 0x00CC while full -> ignored, head stays 11CC, count 8.
- Equal keys 0x4001 then 0x4002 then dequeue twice -> values 01 then 02.
- Replace with head 11CC, new 0x20AA -> last-dequeued=11CC, head=20AA, count unchanged, busy=1 one cycle.
